alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 96 +++++++++
 rtl/alu_wrapper.sv | 71 +++++++
 rtl/alu_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the two-requester ALU arbiter and its ALU wrapper:
//   - DATA_W_DEFAULT : default operand/result width
//   - OPC_*          : 5-bit instruction opcodes presented by requesters
//   - ALU_*          : 3-bit internal ALU operation codes
//   - state_e        : arbiter FSM states
//   - decode_opcode  : maps an instruction opcode to ALU op, operand select
//                      and result source
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W_DEFAULT = 32;

  // Instruction opcodes
  localparam logic [4:0] OPC_ADD   = 5'd0;
  localparam logic [4:0] OPC_ADDI  = 5'd1;
  localparam logic [4:0] OPC_SUB   = 5'd2;
  localparam logic [4:0] OPC_SUBI  = 5'd3;
  localparam logic [4:0] OPC_MUL   = 5'd4;
  localparam logic [4:0] OPC_DIV   = 5'd5;
  localparam logic [4:0] OPC_AND   = 5'd6;
  localparam logic [4:0] OPC_ANDI  = 5'd7;
  localparam logic [4:0] OPC_OR    = 5'd8;
  localparam logic [4:0] OPC_ORI   = 5'd9;
  localparam logic [4:0] OPC_NOT   = 5'd10;
  localparam logic [4:0] OPC_XOR   = 5'd11;
  localparam logic [4:0] OPC_XORI  = 5'd12;
  localparam logic [4:0] OPC_CMP   = 5'd13;
  localparam logic [4:0] OPC_LD    = 5'd14;
  localparam logic [4:0] OPC_ST    = 5'd15;
  localparam logic [4:0] OPC_MOVEH = 5'd16;
  localparam logic [4:0] OPC_MOVEL = 5'd17;

  // Internal ALU operations
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_MUL = 3'd2;
  localparam logic [2:0] ALU_DIV = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;
  localparam logic [2:0] ALU_NOT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Where the wrapper's result comes from
  typedef enum logic [2:0] {
    RES_ALU   = 3'd0,  // ALU core result
    RES_CMP   = 3'd1,  // flags from a-b, data forced to zero
    RES_MOVEH = 3'd2,  // imm low half into upper half of a
    RES_MOVEL = 3'd3,  // imm low half into lower half of a
    RES_NONE  = 3'd4   // unknown opcode: zero data, zero flags
  } res_sel_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       use_imm;
    res_sel_e   res_sel;
  } op_decode_t;

  function automatic op_decode_t decode_opcode(input logic [4:0] opcode);
    op_decode_t d;
    d.alu_op  = ALU_ADD;
    d.use_imm = 1'b0;
    d.res_sel = RES_ALU;
    case (opcode)
      OPC_ADD:   d.alu_op = ALU_ADD;
      OPC_ADDI:  begin d.alu_op = ALU_ADD; d.use_imm = 1'b1; end
      OPC_SUB:   d.alu_op = ALU_SUB;
      OPC_SUBI:  begin d.alu_op = ALU_SUB; d.use_imm = 1'b1; end
      OPC_MUL:   d.alu_op = ALU_MUL;
      OPC_DIV:   d.alu_op = ALU_DIV;
      OPC_AND:   d.alu_op = ALU_AND;
      OPC_ANDI:  begin d.alu_op = ALU_AND; d.use_imm = 1'b1; end
      OPC_OR:    d.alu_op = ALU_OR;
      OPC_ORI:   begin d.alu_op = ALU_OR; d.use_imm = 1'b1; end
      OPC_NOT:   d.alu_op = ALU_NOT;
      OPC_XOR:   d.alu_op = ALU_XOR;
      OPC_XORI:  begin d.alu_op = ALU_XOR; d.use_imm = 1'b1; end
      OPC_CMP:   begin d.alu_op = ALU_SUB; d.res_sel = RES_CMP; end
      // LD/ST produce the effective address a + imm
      OPC_LD,
      OPC_ST:    begin d.alu_op = ALU_ADD; d.use_imm = 1'b1; end
      OPC_MOVEH: d.res_sel = RES_MOVEH;
      OPC_MOVEL: d.res_sel = RES_MOVEL;
      default:   d.res_sel = RES_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_wrapper.sv
// -----------------------------------------------------------------------------
// alu_wrapper
// Purely combinational ALU. Decodes a 5-bit instruction opcode and produces a
// DATA_W-bit result plus two flags. All arithmetic wraps at DATA_W bits; MUL
// keeps the low DATA_W bits; DIV by zero returns all ones.
// flags[1] = sign bit of the evaluated value, flags[0] = evaluated value is 0.
// For CMP the evaluated value is a-b and out is 0. Unknown opcodes give
// out = 0 and flags = 0. DATA_W is expected to be even for MOVEH/MOVEL.
// Ports:
//   a, b, imm : operands (imm replaces b for the immediate forms)
//   opcode    : 5-bit instruction opcode
//   out       : result
//   flags     : {sign, zero}
// -----------------------------------------------------------------------------
module alu_wrapper
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  logic [4:0]        opcode,
  output logic [DATA_W-1:0] out,
  output logic [1:0]        flags
);

  localparam int HALF_W = DATA_W / 2;

  op_decode_t        w_dec;
  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_core;
  logic [DATA_W-1:0] w_flag_src;

  assign w_dec = decode_opcode(opcode);
  assign w_opb = w_dec.use_imm ? imm : b;

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_core = '0;
    case (w_dec.alu_op)
      ALU_ADD: w_core = a + w_opb;
      ALU_SUB: w_core = a - w_opb;
      ALU_MUL: w_core = a * w_opb;
      ALU_DIV: w_core = (w_opb == '0) ? '1 : a / w_opb;
      ALU_AND: w_core = a & w_opb;
      ALU_OR:  w_core = a | w_opb;
      ALU_XOR: w_core = a ^ w_opb;
      ALU_NOT: w_core = ~a;
      default: w_core = '0;
    endcase
  end

  always_comb begin
    out        = '0;
    flags      = '0;
    w_flag_src = '0;
    case (w_dec.res_sel)
      RES_ALU:   out = w_core;
      RES_MOVEH: out = {imm[HALF_W-1:0], a[DATA_W-HALF_W-1:0]};
      RES_MOVEL: out = {a[DATA_W-1:HALF_W], imm[HALF_W-1:0]};
      default:   out = '0;
    endcase
    w_flag_src = (w_dec.res_sel == RES_CMP) ? w_core : out;
    if (w_dec.res_sel != RES_NONE) begin
      flags = {w_flag_src[DATA_W-1], (w_flag_src == '0)};
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one alu_wrapper between two requesters. A three-state FSM
// (IDLE -> EXEC -> RESP) accepts one operation at a time, round-robin on ties,
// executes it from captured registers and holds the result until the owning
// requester takes it.
// Timing: accept edge k, result registered at edge k+1, rspN_valid from then
// until the rspN_ready handshake; minimum issue interval is 3 cycles.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid / reqN_ready  : request handshake (ready combinational in IDLE)
//   reqN_opcode, reqN_a/b/imm: operation presented by requester N
//   rspN_valid / rspN_ready  : response handshake for requester N
//   rsp_data, rsp_flags      : shared registered result bus
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [4:0]        req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req0_imm,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [4:0]        req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [DATA_W-1:0] req1_imm,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_flags
);

  state_e            r_state;
  state_e            w_next_state;

  logic              r_last_grant;  // ID granted most recently
  logic              r_owner;       // ID of the operation in flight
  logic [4:0]        r_opcode;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_result;
  logic [1:0]        r_flags;

  logic              w_accept;
  logic              w_grant_id;
  logic              w_owner_rsp_ready;
  logic [4:0]        w_sel_opcode;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [DATA_W-1:0] w_sel_imm;
  logic [DATA_W-1:0] w_alu_out;
  logic [1:0]        w_alu_flags;

  // The ALU only ever sees the captured operands, never the live request
  // buses, so requesters may change their inputs once accepted.
  alu_wrapper #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (r_a),
    .b      (r_b),
    .imm    (r_imm),
    .opcode (r_opcode),
    .out    (w_alu_out),
    .flags  (w_alu_flags)
  );

  assign w_owner_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

  assign w_sel_opcode = w_grant_id ? req1_opcode : req0_opcode;
  assign w_sel_a      = w_grant_id ? req1_a      : req0_a;
  assign w_sel_b      = w_grant_id ? req1_b      : req0_b;
  assign w_sel_imm    = w_grant_id ? req1_imm    : req0_imm;

  // Next state and handshake outputs. Outputs are held low while rst is high
  // so nothing is offered or accepted during reset.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_grant_id   = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (req0_valid || req1_valid) begin
            w_accept = 1'b1;
            // Tie goes to the requester not granted last; a lone requester
            // wins regardless of the pointer.
            if (req0_valid && req1_valid) begin
              w_grant_id = ~r_last_grant;
            end else begin
              w_grant_id = req1_valid;
            end
            req0_ready   = ~w_grant_id;
            req1_ready   = w_grant_id;
            w_next_state = ST_EXEC;
          end
        end
        ST_EXEC: begin
          w_next_state = ST_RESP;
        end
        ST_RESP: begin
          rsp0_valid = ~r_owner;
          rsp1_valid = r_owner;
          // Only the owner's ready is looked at; the other one is ignored.
          if (w_owner_rsp_ready) begin
            w_next_state = ST_IDLE;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: these are plain registers, not a memory, so all of them are reset
  // to zero; an operation in flight is discarded by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;  // requester 0 wins the first tie
      r_owner      <= 1'b0;
      r_opcode     <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_imm        <= '0;
      r_result     <= '0;
      r_flags      <= '0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant_id;
        r_owner      <= w_grant_id;
        r_opcode     <= w_sel_opcode;
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        r_imm        <= w_sel_imm;
      end
      if (r_state == ST_EXEC) begin
        r_result <= w_alu_out;
        r_flags  <= w_alu_flags;
      end
    end
  end

  assign rsp_data  = r_result;
  assign rsp_flags = r_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: a table of single operations with
// hand-computed results, plus hand-written sequences for arbitration, stalls
// and reset. Expected responses are queued when an accept is observed and
// popped when the DUT presents the response.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [4:0]    req0_opcode, req1_opcode;
  logic [DW-1:0] req0_a, req0_b, req0_imm;
  logic [DW-1:0] req1_a, req1_b, req1_imm;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_flags;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_opcode (req0_opcode),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_imm    (req0_imm),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_opcode (req1_opcode),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_imm    (req1_imm),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp_data    (rsp_data),
    .rsp_flags   (rsp_flags)
  );

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    logic [1:0]    flags;
    string         name;
  } exp_t;

  typedef struct {
    string         name;
    logic          id;
    logic [4:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_flags;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to just after the next falling edge (sample/drive point).
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [4:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] imm);
    if (id == 1'b0) begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b; req0_imm = imm;
    end else begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b; req1_imm = imm;
    end
  endtask

  task automatic drop_req(input logic id);
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  task automatic push_exp(input logic id, input logic [DW-1:0] data,
                          input logic [1:0] flags, input string name);
    exp_t e;
    e.id = id; e.data = data; e.flags = flags; e.name = name;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) until requester id is granted; the other must not be.
  task automatic wait_accept(input logic id, input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      check({name, "_accept_timeout"}, 64'd0, 64'd1);
    end else begin
      check({name, "_other_ready"}, id ? req0_ready : req1_ready, 64'd0);
    end
  endtask

  // Wait (bounded) for rspN_valid; while busy no request may be granted.
  task automatic wait_rsp(input logic id, input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if ((id ? rsp1_valid : rsp0_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      check({name, "_busy_ready"}, {62'd0, req0_ready, req1_ready}, 64'd0);
      step();
    end
    if (!ok) check({name, "_rsp_timeout"}, 64'd0, 64'd1);
  endtask

  // Compare the presented response against the scoreboard and consume it.
  task automatic consume(input logic id);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    check({e.name, "_data"}, rsp_data, e.data);
    check({e.name, "_flags"}, rsp_flags, e.flags);
    check({e.name, "_other_rsp_valid"}, id ? rsp0_valid : rsp1_valid, 64'd0);
    if (id == 1'b0) rsp0_ready = 1'b1;
    else            rsp1_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  // Single operation from one requester, with latency check.
  task automatic transact(input vec_t v);
    bit ok;
    int unsigned c_acc;
    set_req(v.id, 1'b1, v.op, v.a, v.b, v.imm);
    #1;
    wait_accept(v.id, v.name, ok);
    if (!ok) begin
      drop_req(v.id);
      return;
    end
    c_acc = cyc;
    push_exp(v.id, v.exp_data, v.exp_flags, v.name);
    step();
    drop_req(v.id);
    wait_rsp(v.id, v.name, ok);
    if (!ok) begin
      void'(sb_q.pop_back());
      return;
    end
    check({v.name, "_latency"}, 64'(cyc - c_acc), 64'd2);
    consume(v.id);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input string name, input logic id, input logic [4:0] op,
                              input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] imm, input logic [DW-1:0] d,
                              input logic [1:0] f);
    vec_t v;
    v.name = name; v.id = id; v.op = op; v.a = a; v.b = b; v.imm = imm;
    v.exp_data = d; v.exp_flags = f;
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int unsigned c_prev;
    logic exp_id;
    int n0, n1;

    rst = 1'b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    set_req(1'b0, 1'b0, 5'd0, '0, '0, '0);
    set_req(1'b1, 1'b0, 5'd0, '0, '0, '0);

    // Reset state, with both requests valid during reset
    step();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    check("rst_req0_ready", req0_ready, 64'd0);
    check("rst_req1_ready", req1_ready, 64'd0);
    check("rst_rsp0_valid", rsp0_valid, 64'd0);
    check("rst_rsp1_valid", rsp1_valid, 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_rsp_flags", rsp_flags, 64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    step();

    // Single-op table (flags = {sign, zero})
    vecs.push_back(mk("add_5_7",   0, OPC_ADD,   32'd5,        32'd7,        32'd0,        32'd12,       2'b00));
    vecs.push_back(mk("addi_wrap", 1, OPC_ADDI,  32'hFFFFFFFF, 32'h55,       32'd1,        32'd0,        2'b01));
    vecs.push_back(mk("sub_neg",   0, OPC_SUB,   32'd3,        32'd5,        32'd0,        32'hFFFFFFFE, 2'b10));
    vecs.push_back(mk("subi",      1, OPC_SUBI,  32'd10,       32'h99,       32'd3,        32'd7,        2'b00));
    vecs.push_back(mk("mul_wrap",  0, OPC_MUL,   32'h10000,    32'h10000,    32'd0,        32'd0,        2'b01));
    vecs.push_back(mk("mul",       1, OPC_MUL,   32'd7,        32'd6,        32'd0,        32'd42,       2'b00));
    vecs.push_back(mk("div",       0, OPC_DIV,   32'd100,      32'd7,        32'd0,        32'd14,       2'b00));
    vecs.push_back(mk("div_zero",  1, OPC_DIV,   32'd9,        32'd0,        32'd0,        32'hFFFFFFFF, 2'b10));
    vecs.push_back(mk("and",       0, OPC_AND,   32'hF0F0,     32'h0FF0,     32'd0,        32'h00F0,     2'b00));
    vecs.push_back(mk("andi",      1, OPC_ANDI,  32'hFF,       32'd0,        32'h0F,       32'h0F,       2'b00));
    vecs.push_back(mk("or",        0, OPC_OR,    32'hF000,     32'h000F,     32'd0,        32'hF00F,     2'b00));
    vecs.push_back(mk("ori",       1, OPC_ORI,   32'd0,        32'd1,        32'h80000000, 32'h80000000, 2'b10));
    vecs.push_back(mk("not",       0, OPC_NOT,   32'd0,        32'h123,      32'd0,        32'hFFFFFFFF, 2'b10));
    vecs.push_back(mk("xor_zero",  1, OPC_XOR,   32'hFF,       32'hFF,       32'd0,        32'd0,        2'b01));
    vecs.push_back(mk("xori",      0, OPC_XORI,  32'hAA,       32'hFF,       32'h55,       32'hFF,       2'b00));
    vecs.push_back(mk("cmp_eq",    1, OPC_CMP,   32'd5,        32'd5,        32'd0,        32'd0,        2'b01));
    vecs.push_back(mk("cmp_lt",    0, OPC_CMP,   32'd3,        32'd5,        32'd0,        32'd0,        2'b10));
    vecs.push_back(mk("cmp_gt",    1, OPC_CMP,   32'd9,        32'd5,        32'd0,        32'd0,        2'b00));
    vecs.push_back(mk("ld",        0, OPC_LD,    32'h1000,     32'd7,        32'h20,       32'h1020,     2'b00));
    vecs.push_back(mk("st",        1, OPC_ST,    32'h100,      32'd9,        32'd4,        32'h104,      2'b00));
    vecs.push_back(mk("moveh",     0, OPC_MOVEH, 32'h12345678, 32'd0,        32'hFFFFABCD, 32'hABCD5678, 2'b10));
    vecs.push_back(mk("movel",     1, OPC_MOVEL, 32'h12345678, 32'd0,        32'h9999ABCD, 32'h1234ABCD, 2'b00));
    vecs.push_back(mk("unlisted31",0, 5'd31,     32'd5,        32'd5,        32'd0,        32'd0,        2'b00));
    vecs.push_back(mk("unlisted18",1, 5'd18,     32'd5,        32'd5,        32'd0,        32'd0,        2'b00));

    for (int i = 0; i < vecs.size(); i++) begin
      transact(vecs[i]);
    end

    // Tie after reset: requester 0 first, then requester 1 in the next IDLE
    do_reset();
    set_req(1'b0, 1'b1, OPC_SUBI, 32'd10, 32'd0, 32'd3);
    set_req(1'b1, 1'b1, OPC_AND, 32'hF0F0, 32'h0FF0, 32'd0);
    #1;
    wait_accept(1'b0, "tie_req0", ok);
    if (ok) begin
      push_exp(1'b0, 32'd7, 2'b00, "tie_req0");
      step();
      drop_req(1'b0);
      wait_rsp(1'b0, "tie_req0", ok);
      if (ok) consume(1'b0);
      check("tie_req1_grant_next_idle", req1_ready, 64'd1);
      wait_accept(1'b1, "tie_req1", ok);
      if (ok) begin
        push_exp(1'b1, 32'h00F0, 2'b00, "tie_req1");
        step();
        drop_req(1'b1);
        wait_rsp(1'b1, "tie_req1", ok);
        if (ok) consume(1'b1);
      end
    end
    drop_req(1'b0);
    drop_req(1'b1);

    // Both held valid: grants alternate 0,1,0,1,0,1
    do_reset();
    n0 = 0;
    n1 = 0;
    set_req(1'b0, 1'b1, OPC_ADD, 32'd10, 32'd1, 32'd0);
    set_req(1'b1, 1'b1, OPC_SUB, 32'd100, 32'd1, 32'd0);
    #1;
    for (int g = 0; g < 6; g++) begin
      exp_id = logic'(g % 2);
      ok = 1'b0;
      for (int t = 0; t < 10; t++) begin
        if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
          ok = 1'b1;
          break;
        end
        step();
      end
      if (!ok) begin
        check($sformatf("rr_timeout%0d", g), 64'd0, 64'd1);
        break;
      end
      check($sformatf("rr_grant%0d", g), {62'd0, req1_ready, req0_ready},
            exp_id ? 64'd2 : 64'd1);
      if (exp_id == 1'b0) begin
        push_exp(1'b0, 32'(11 + n0), 2'b00, $sformatf("rr_op%0d", g));
        n0++;
        step();
        set_req(1'b0, 1'b1, OPC_ADD, 32'(10 + n0), 32'd1, 32'd0);
      end else begin
        push_exp(1'b1, 32'(99 - n1), 2'b00, $sformatf("rr_op%0d", g));
        n1++;
        step();
        set_req(1'b1, 1'b1, OPC_SUB, 32'd100, 32'(1 + n1), 32'd0);
      end
      wait_rsp(exp_id, $sformatf("rr_op%0d", g), ok);
      if (!ok) begin
        void'(sb_q.pop_back());
        break;
      end
      consume(exp_id);
    end
    drop_req(1'b0);
    drop_req(1'b1);

    // Response stall: req1 result held 4 cycles, req0 waits, rsp0_ready ignored
    do_reset();
    set_req(1'b1, 1'b1, OPC_MUL, 32'h10000, 32'h10000, 32'd0);
    #1;
    wait_accept(1'b1, "stall_mul", ok);
    if (ok) begin
      push_exp(1'b1, 32'd0, 2'b01, "stall_mul");
      step();
      drop_req(1'b1);
      set_req(1'b0, 1'b1, OPC_XOR, 32'hF, 32'h3, 32'd0);
      rsp0_ready = 1'b1;
      wait_rsp(1'b1, "stall_mul", ok);
      if (ok) begin
        for (int i = 0; i < 4; i++) begin
          check($sformatf("stall%0d_rsp1_valid", i), rsp1_valid, 64'd1);
          check($sformatf("stall%0d_rsp_data", i), rsp_data, 64'd0);
          check($sformatf("stall%0d_rsp_flags", i), rsp_flags, 64'd1);
          check($sformatf("stall%0d_req0_ready", i), req0_ready, 64'd0);
          check($sformatf("stall%0d_rsp0_valid", i), rsp0_valid, 64'd0);
          step();
        end
        rsp0_ready = 1'b0;
        consume(1'b1);
        check("stall_held_req0_grant", req0_ready, 64'd1);
        wait_accept(1'b0, "stall_req0", ok);
        if (ok) begin
          push_exp(1'b0, 32'hC, 2'b00, "stall_req0");
          step();
          drop_req(1'b0);
          wait_rsp(1'b0, "stall_req0", ok);
          if (ok) consume(1'b0);
        end
      end
    end
    rsp0_ready = 1'b0;
    drop_req(1'b0);
    drop_req(1'b1);

    // Reset during EXEC discards the operation
    set_req(1'b0, 1'b1, OPC_ADD, 32'd1, 32'd1, 32'd0);
    #1;
    wait_accept(1'b0, "rst_exec", ok);
    if (ok) begin
      step();
      drop_req(1'b0);
      rst = 1'b1;
      step();
      check("rst_exec_req0_ready", req0_ready, 64'd0);
      check("rst_exec_rsp0_valid", rsp0_valid, 64'd0);
      check("rst_exec_rsp1_valid", rsp1_valid, 64'd0);
      check("rst_exec_rsp_data", rsp_data, 64'd0);
      check("rst_exec_rsp_flags", rsp_flags, 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
        step();
        check($sformatf("rst_exec_no_rsp%0d", i), {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
      end
      set_req(1'b0, 1'b1, OPC_ADD, 32'd2, 32'd3, 32'd0);
      set_req(1'b1, 1'b1, OPC_ADD, 32'd4, 32'd4, 32'd0);
      #1;
      wait_accept(1'b0, "rst_tie_req0", ok);
      if (ok) begin
        push_exp(1'b0, 32'd5, 2'b00, "rst_tie_req0");
        step();
        drop_req(1'b0);
        wait_rsp(1'b0, "rst_tie_req0", ok);
        if (ok) consume(1'b0);
        wait_accept(1'b1, "rst_tie_req1", ok);
        if (ok) begin
          push_exp(1'b1, 32'd8, 2'b00, "rst_tie_req1");
          step();
          drop_req(1'b1);
          wait_rsp(1'b1, "rst_tie_req1", ok);
          if (ok) consume(1'b1);
        end
      end
    end
    drop_req(1'b0);
    drop_req(1'b1);

    // Only req1 valid, 3 back-to-back ops, accepts 3 cycles apart
    c_prev = 0;
    set_req(1'b1, 1'b1, OPC_ADD, 32'd0, 32'd10, 32'd0);
    #1;
    for (int k = 0; k < 3; k++) begin
      wait_accept(1'b1, $sformatf("b2b%0d", k), ok);
      if (!ok) break;
      if (k > 0) check($sformatf("b2b%0d_spacing", k), 64'(cyc - c_prev), 64'd3);
      c_prev = cyc;
      push_exp(1'b1, 32'(10 + k), 2'b00, $sformatf("b2b%0d", k));
      step();
      if (k < 2) set_req(1'b1, 1'b1, OPC_ADD, 32'(k + 1), 32'd10, 32'd0);
      else       drop_req(1'b1);
      wait_rsp(1'b1, $sformatf("b2b%0d", k), ok);
      if (!ok) begin
        void'(sb_q.pop_back());
        break;
      end
      consume(1'b1);
    end
    drop_req(1'b1);

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
